mc_controller: RTL and testbench
================================

# mc_controller

Multicycle control unit for the RISC-V core. It replaces the single-cycle opcode decoder with a Moore state machine that sequences fetch, decode, execute, memory and writeback over several cycles, with an optional memory ready handshake. It decodes lw, sw, R-type, I-type ALU, beq/bne, jal, jalr, lui and auipc, flags illegal encodings, and counts retired instructions. It sits beside the multicycle datapath; ALU function decode stays in the existing ALU decoder, driven by ALUOp.

## Interface
Parameters:
- MEM_HANDSHAKE, 1: 1 = memory states wait for MemReady; 0 = MemReady is ignored and treated as 1.
- TRAP_ILLEGAL, 1: 1 = an illegal instruction halts in ILLEGAL; 0 = it is treated as a nop.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk, in, 1: clock; all state changes on the rising edge.
- reset, in, 1: synchronous, active-high.
- op, in, 7: instruction opcode (IR[6:0]).
- funct3, in, 3: IR[14:12].
- Zero, in, 1: ALU zero flag.
- MemReady, in, 1: memory completes the current access this cycle.
- PCWrite, out, 1: PC register enable.
- AdrSrc, out, 1: memory address select; 0 = PC, 1 = ALUOut.
- IRWrite, out, 1: instruction register and OldPC enable.
- MemWrite, out, 1: store strobe.
- MemReq, out, 1: memory access request.
- RegWrite, out, 1: register file write enable.
- ResultSrc, out, 2: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- ALUSrcA, out, 2: 00 = PC, 01 = OldPC, 10 = RD1, 11 = zero.
- ALUSrcB, out, 2: 00 = RD2, 01 = ImmExt, 10 = 4.
- ALUOp, out, 2: 00 = add, 01 = subtract/compare, 10 = decode by funct.
- ImmSrc, out, 3: 000 = I, 001 = S, 010 = B, 011 = J, 100 = U.
- IllegalInstr, out, 1: sticky illegal-instruction flag.
- State, out, 4: current state, for debug.
- InstRet, out, CNT_W: count of retired instructions.

## Operation
**State encodings:** FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9, JAL 10, JALRADR 11, JALR 12, LUI 13, AUIPC 14, ILLEGAL 15.

**Output defaults:** every output not listed for a state is 0.

**ImmSrc:** purely combinational from op in every state.
- I for 0000011, 0010011 and 1100111.
- S for 0100011; B for 1100011; J for 1101111.
- U for 0110111 and 0010111.
- 000 otherwise.

**States and transitions:**
- FETCH: MemReq=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ResultSrc=10. IRWrite and PCWrite equal the effective MemReady. Moves to DECODE on effective MemReady, otherwise holds.
- DECODE: ALUSrcA=01, ALUSrcB=01 (branch/jal target into ALUOut). Next state by op:
  - lw/sw → MEMADR; R-type → EXECR; I-type ALU → EXECI.
  - branch → BRANCH if funct3 is 000 or 001, else illegal.
  - jal → JAL; jalr → JALRADR; lui → LUI; auipc → AUIPC.
  - Any other op is illegal. Illegal goes to ILLEGAL if TRAP_ILLEGAL=1, else to FETCH.
- MEMADR: ALUSrcA=10, ALUSrcB=01. Next is MEMREAD for op 0000011, otherwise MEMWRITE.
- MEMREAD: MemReq=1, AdrSrc=1. Moves to MEMWB on effective MemReady, otherwise holds.
- MEMWB: ResultSrc=01, RegWrite=1. Next is FETCH.
- MEMWRITE: MemReq=1, MemWrite=1, AdrSrc=1. Moves to FETCH on effective MemReady; MemWrite stays high while waiting.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next is ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Next is ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1. Next is FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00. PCWrite = (funct3==000 ? Zero : ~Zero). Next is FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ResultSrc=00, PCWrite=1. Next is ALUWB, which writes OldPC+4 to rd.
- JALRADR: ALUSrcA=10, ALUSrcB=01. Next is JALR.
- JALR: same outputs as JAL. Next is ALUWB.
- LUI: ALUSrcA=11, ALUSrcB=01. Next is ALUWB.
- AUIPC: ALUSrcA=01, ALUSrcB=01. Next is ALUWB.
- ILLEGAL: all enables 0, IllegalInstr=1. Holds until reset.

**Retirement counter:** InstRet increments by 1 (modulo 2^CNT_W) in any cycle where the state is one of:
- MEMWB or ALUWB;
- BRANCH;
- MEMWRITE with effective MemReady;
- DECODE taking the illegal path with TRAP_ILLEGAL=0.

## Timing
- **Reset:** on a clk edge with reset=1: State ← FETCH, InstRet ← 0, IllegalInstr ← 0.
- **Gating during reset:** while reset=1, PCWrite, IRWrite, RegWrite, MemWrite and MemReq are forced 0. This applies even mid-access, e.g. reset asserted in MEMREAD or MEMWRITE.
- **Output timing:** all outputs are Moore functions of State. The exceptions are PCWrite/IRWrite in FETCH (MemReady), PCWrite in BRANCH (Zero/funct3) and ImmSrc (op); these are combinational.
- **Latency with MemReady=1:**

| Instruction | Cycles |
|---|---|
| branch | 3 |
| R-type, I-type, lui, auipc | 4 |
| sw | 4 |
| jal | 4 |
| lw | 5 |
| jalr | 5 |

- **Wait states:** each cycle MemReady is low in FETCH, MEMREAD or MEMWRITE adds one cycle. No outputs change while waiting.
- **MemReady outside memory states:** MemReady high in any non-memory state is ignored.

## Test plan
- **lw with delayed ready:** op=0000011, MemReady low for 2 cycles in both FETCH and MEMREAD → states 0,0,0,1,2,3,3,3,4,0; RegWrite=1 only in state 4; InstRet increments by 1.
- **Branches:** beq with Zero=1 → PCWrite=1 in BRANCH; beq with Zero=0 → PCWrite=0; bne with Zero=0 → PCWrite=1; each completes in 3 cycles.
- **jal, then jalr:** states 0,1,10,8 then 0,1,11,12,8; PCWrite=1 in states 10 and 12; ResultSrc=00 and RegWrite=1 in state 8.
- **Illegal op, TRAP_ILLEGAL=1:** op=1111111 → State=15, IllegalInstr=1, all enables 0 for 10 cycles; reset → State=0, IllegalInstr=0.
- **Illegal op, TRAP_ILLEGAL=0:** op=1111111, or branch with funct3=010 → DECODE→FETCH; IllegalInstr stays 0; InstRet increments.
- **Reset mid-access, then counter wrap:** reset asserted in MEMWRITE with MemReady=0 → MemWrite=0 that cycle, State=0 next cycle. With CNT_W=4, 16 addi instructions → InstRet wraps to 0.

Source files
------------

// File: rtl/mc_controller.sv
// Multicycle RISC-V control unit: Moore FSM sequencing fetch, decode,
// execute, memory and writeback, with optional memory ready handshake,
// illegal-instruction trapping and a retired-instruction counter.
module mc_controller #(
  parameter bit          MEM_HANDSHAKE = 1'b1,
  parameter bit          TRAP_ILLEGAL  = 1'b1,
  parameter int unsigned CNT_W         = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             Zero,
  input  logic             MemReady,
  output logic             PCWrite,
  output logic             AdrSrc,
  output logic             IRWrite,
  output logic             MemWrite,
  output logic             MemReq,
  output logic             RegWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [2:0]       ImmSrc,
  output logic             IllegalInstr,
  output logic [3:0]       State,
  output logic [CNT_W-1:0] InstRet
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALRADR  = 4'd11,
    S_JALR     = 4'd12,
    S_LUI      = 4'd13,
    S_AUIPC    = 4'd14,
    S_ILLEGAL  = 4'd15
  } state_t;

  state_t           state_q, state_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] instret_q, instret_d;

  logic mem_rdy;
  logic retire;
  logic decode_bad;
  logic pc_we, ir_we, mem_we, mem_req, reg_we;

  assign mem_rdy = MEM_HANDSHAKE ? MemReady : 1'b1;

  // State register, sticky illegal flag and retirement counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      instret_q <= instret_d;
    end
  end

  // Next state and Moore control outputs; MemReady/Zero only steer FETCH,
  // the memory states and BRANCH
  always_comb begin
    state_d    = state_q;
    illegal_d  = illegal_q;
    retire     = 1'b0;
    decode_bad = 1'b0;
    pc_we      = 1'b0;
    ir_we      = 1'b0;
    mem_we     = 1'b0;
    mem_req    = 1'b0;
    reg_we     = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = '0;
    ALUSrcA    = '0;
    ALUSrcB    = '0;
    ALUOp      = '0;
    case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        ir_we     = mem_rdy;
        pc_we     = mem_rdy;
        if (mem_rdy) state_d = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_BRANCH: begin
            if (funct3 == 3'b000 || funct3 == 3'b001) state_d = S_BRANCH;
            else                                      decode_bad = 1'b1;
          end
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALRADR;
          OP_LUI:            state_d = S_LUI;
          OP_AUIPC:          state_d = S_AUIPC;
          default:           decode_bad = 1'b1;
        endcase
        // Without trapping, an illegal encoding retires as a nop from DECODE
        if (decode_bad) begin
          if (TRAP_ILLEGAL) begin
            state_d   = S_ILLEGAL;
            illegal_d = 1'b1;
          end else begin
            state_d = S_FETCH;
            retire  = 1'b1;
          end
        end
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
        if (mem_rdy) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        reg_we    = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        AdrSrc  = 1'b1;
        if (mem_rdy) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b00;
        ALUOp   = 2'b10;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        reg_we  = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b00;
        ALUOp   = 2'b01;
        pc_we   = (funct3 == 3'b000) ? Zero : ~Zero;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_JAL, S_JALR: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        pc_we   = 1'b1;
        state_d = S_ALUWB;
      end
      S_JALRADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = S_JALR;
      end
      S_LUI: begin
        ALUSrcA = 2'b11;
        ALUSrcB = 2'b01;
        state_d = S_ALUWB;
      end
      S_AUIPC: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        state_d = S_ALUWB;
      end
      S_ILLEGAL: begin
        state_d = S_ILLEGAL;
      end
    endcase
  end

  assign instret_d = retire ? instret_q + CNT_W'(1) : instret_q;

  // Enables are forced low while reset is held, even mid-access
  assign PCWrite  = pc_we   & ~reset;
  assign IRWrite  = ir_we   & ~reset;
  assign MemWrite = mem_we  & ~reset;
  assign MemReq   = mem_req & ~reset;
  assign RegWrite = reg_we  & ~reset;

  // Immediate format follows the opcode in every state
  always_comb begin
    ImmSrc = 3'b000;
    case (op)
      OP_LOAD, OP_ITYPE, OP_JALR: ImmSrc = 3'b000;
      OP_STORE:                   ImmSrc = 3'b001;
      OP_BRANCH:                  ImmSrc = 3'b010;
      OP_JAL:                     ImmSrc = 3'b011;
      OP_LUI, OP_AUIPC:           ImmSrc = 3'b100;
      default:                    ImmSrc = 3'b000;
    endcase
  end

  assign State        = state_q;
  assign IllegalInstr = illegal_q;
  assign InstRet      = instret_q;

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: two instances (trapping/32-bit counter and
// non-trapping/4-bit counter), directed vector tables, a counter-wrap
// sequence and a randomized instruction stream against a sequence model.
module tb_mc_controller;

  localparam logic [6:0] OP_LW   = 7'h03;
  localparam logic [6:0] OP_SW   = 7'h23;
  localparam logic [6:0] OP_R    = 7'h33;
  localparam logic [6:0] OP_I    = 7'h13;
  localparam logic [6:0] OP_BR   = 7'h63;
  localparam logic [6:0] OP_JAL  = 7'h6F;
  localparam logic [6:0] OP_JALR = 7'h67;
  localparam logic [6:0] OP_LUI  = 7'h37;
  localparam logic [6:0] OP_AUI  = 7'h17;
  localparam logic [6:0] OP_BAD  = 7'h7F;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst [2];
  logic [6:0] op  [2];
  logic [2:0] f3  [2];
  logic       z   [2];
  logic       rdy [2];

  logic       pcw [2], adr [2], irw [2], mw [2], mq [2], rw [2], ill [2];
  logic [1:0] res [2], sa [2], sb [2], aop [2];
  logic [2:0] imm [2];
  logic [3:0] st  [2];
  logic [31:0] ir0;
  logic [3:0]  ir1;
  logic [31:0] iret [2];
  assign iret[0] = ir0;
  assign iret[1] = {28'd0, ir1};

  mc_controller #(.MEM_HANDSHAKE(1'b1), .TRAP_ILLEGAL(1'b1), .CNT_W(32)) dut0 (
    .clk(clk), .reset(rst[0]), .op(op[0]), .funct3(f3[0]), .Zero(z[0]),
    .MemReady(rdy[0]), .PCWrite(pcw[0]), .AdrSrc(adr[0]), .IRWrite(irw[0]),
    .MemWrite(mw[0]), .MemReq(mq[0]), .RegWrite(rw[0]), .ResultSrc(res[0]),
    .ALUSrcA(sa[0]), .ALUSrcB(sb[0]), .ALUOp(aop[0]), .ImmSrc(imm[0]),
    .IllegalInstr(ill[0]), .State(st[0]), .InstRet(ir0)
  );

  mc_controller #(.MEM_HANDSHAKE(1'b1), .TRAP_ILLEGAL(1'b0), .CNT_W(4)) dut1 (
    .clk(clk), .reset(rst[1]), .op(op[1]), .funct3(f3[1]), .Zero(z[1]),
    .MemReady(rdy[1]), .PCWrite(pcw[1]), .AdrSrc(adr[1]), .IRWrite(irw[1]),
    .MemWrite(mw[1]), .MemReq(mq[1]), .RegWrite(rw[1]), .ResultSrc(res[1]),
    .ALUSrcA(sa[1]), .ALUSrcB(sb[1]), .ALUOp(aop[1]), .ImmSrc(imm[1]),
    .IllegalInstr(ill[1]), .State(st[1]), .InstRet(ir1)
  );

  int unsigned checks   = 0;
  int unsigned failures = 0;

  task automatic chk(input string nm, input int unsigned d,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d got=%0d exp=%0d t=%0t", nm, d, act, exp, $time);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    int unsigned d;
    bit          r;
    logic [6:0]  o;
    logic [2:0]  f;
    bit          zz;
    bit          rd;
    logic [3:0]  s;
    bit          w, p, m, q, i;
    int unsigned rt;
  } vec_t;

  vec_t tbl[$];

  task automatic addv(input int unsigned d, input bit r, input logic [6:0] o,
                      input logic [2:0] f, input bit zz, input bit rd,
                      input logic [3:0] s, input bit w, input bit p, input bit m,
                      input bit q, input bit i, input int unsigned rt);
    vec_t v;
    v.d = d; v.r = r; v.o = o; v.f = f; v.zz = zz; v.rd = rd;
    v.s = s; v.w = w; v.p = p; v.m = m; v.q = q; v.i = i; v.rt = rt;
    tbl.push_back(v);
  endtask

  task automatic reset_dut(input int unsigned d);
    @(negedge clk);
    rst[d] = 1'b1; rdy[d] = 1'b1;
    #1;
    chk("rst_gate_memreq", d, 32'(mq[d]), 0);
    chk("rst_gate_pcwrite", d, 32'(pcw[d]), 0);
    chk("rst_gate_irwrite", d, 32'(irw[d]), 0);
    @(negedge clk);
    rst[d] = 1'b0; rdy[d] = 1'b0;
    #1;
    chk("rst_state", d, 32'(st[d]), 0);
    chk("rst_illegal", d, 32'(ill[d]), 0);
    chk("rst_instret", d, iret[d], 0);
  endtask

  // ---------------- sequence model for random stream ----------------
  typedef struct {
    logic [3:0] st;
    bit         mem;
    bit         last;
  } step_t;

  step_t       seq  [2][8];
  int unsigned n    [2];
  int unsigned pos  [2];
  int unsigned mret [2];
  bit          mill [2];
  int unsigned illc [2];
  bit          trap [2];
  int unsigned mask [2];

  task automatic push(input int unsigned k, input logic [3:0] s, input bit m, input bit l);
    seq[k][n[k]].st   = s;
    seq[k][n[k]].mem  = m;
    seq[k][n[k]].last = l;
    n[k]++;
  endtask

  // Each instruction class expands to its list of visited states
  task automatic build(input int unsigned k, input logic [6:0] o, input logic [2:0] f);
    bit bad;
    bad = 1'b0;
    n[k] = 0; pos[k] = 0;
    push(k, 4'd0, 1'b1, 1'b0);
    push(k, 4'd1, 1'b0, 1'b0);
    case (o)
      OP_LW:   begin push(k, 4'd2, 0, 0); push(k, 4'd3, 1, 0); push(k, 4'd4, 0, 1); end
      OP_SW:   begin push(k, 4'd2, 0, 0); push(k, 4'd5, 1, 1); end
      OP_R:    begin push(k, 4'd6, 0, 0); push(k, 4'd8, 0, 1); end
      OP_I:    begin push(k, 4'd7, 0, 0); push(k, 4'd8, 0, 1); end
      OP_BR:   if (f <= 3'd1) push(k, 4'd9, 0, 1); else bad = 1'b1;
      OP_JAL:  begin push(k, 4'd10, 0, 0); push(k, 4'd8, 0, 1); end
      OP_JALR: begin push(k, 4'd11, 0, 0); push(k, 4'd12, 0, 0); push(k, 4'd8, 0, 1); end
      OP_LUI:  begin push(k, 4'd13, 0, 0); push(k, 4'd8, 0, 1); end
      OP_AUI:  begin push(k, 4'd14, 0, 0); push(k, 4'd8, 0, 1); end
      default: bad = 1'b1;
    endcase
    if (bad) begin
      if (trap[k]) push(k, 4'd15, 0, 0);
      else         seq[k][1].last = 1'b1;
    end
  endtask

  task automatic new_instr(input int unsigned k);
    logic [6:0] legal [9];
    logic [6:0] illeg [4];
    logic [6:0] o;
    logic [2:0] f;
    legal = '{OP_LW, OP_SW, OP_R, OP_I, OP_BR, OP_JAL, OP_JALR, OP_LUI, OP_AUI};
    illeg = '{OP_BAD, 7'h00, 7'h0F, 7'h73};
    if ($urandom_range(0, 15) == 0) o = illeg[$urandom_range(0, 3)];
    else                            o = legal[$urandom_range(0, 8)];
    if (o == OP_BR) f = 3'($urandom_range(0, 2));
    else            f = 3'($urandom_range(0, 7));
    op[k] = o; f3[k] = f;
    build(k, o, f);
  endtask

  function automatic logic [2:0] exp_imm(input logic [6:0] o);
    case (o)
      OP_SW:           return 3'b001;
      OP_BR:           return 3'b010;
      OP_JAL:          return 3'b011;
      OP_LUI, OP_AUI:  return 3'b100;
      default:         return 3'b000;
    endcase
  endfunction

  function automatic logic [1:0] exp_srca(input logic [3:0] s);
    case (s)
      4'd1, 4'd10, 4'd12, 4'd14:     return 2'b01;
      4'd2, 4'd6, 4'd7, 4'd9, 4'd11: return 2'b10;
      4'd13:                         return 2'b11;
      default:                       return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] exp_srcb(input logic [3:0] s);
    case (s)
      4'd0, 4'd10, 4'd12:                         return 2'b10;
      4'd1, 4'd2, 4'd7, 4'd11, 4'd13, 4'd14:      return 2'b01;
      default:                                    return 2'b00;
    endcase
  endfunction

  task automatic check_model(input int unsigned k);
    logic [3:0] s;
    bit r, e_pcw;
    s = seq[k][pos[k]].st;
    r = rst[k];
    case (s)
      4'd0:         e_pcw = rdy[k];
      4'd9:         e_pcw = (f3[k] == 3'b000) ? z[k] : !z[k];
      4'd10, 4'd12: e_pcw = 1'b1;
      default:      e_pcw = 1'b0;
    endcase
    chk("rnd_state", k, 32'(st[k]), 32'(s));
    chk("rnd_pcwrite", k, 32'(pcw[k]), 32'(e_pcw && !r));
    chk("rnd_irwrite", k, 32'(irw[k]), 32'(s == 4'd0 && rdy[k] && !r));
    chk("rnd_memreq", k, 32'(mq[k]), 32'((s == 4'd0 || s == 4'd3 || s == 4'd5) && !r));
    chk("rnd_memwrite", k, 32'(mw[k]), 32'(s == 4'd5 && !r));
    chk("rnd_regwrite", k, 32'(rw[k]), 32'((s == 4'd4 || s == 4'd8) && !r));
    chk("rnd_adrsrc", k, 32'(adr[k]), 32'(s == 4'd3 || s == 4'd5));
    chk("rnd_resultsrc", k, 32'(res[k]), (s == 4'd0) ? 2 : (s == 4'd4) ? 1 : 0);
    chk("rnd_alusrca", k, 32'(sa[k]), 32'(exp_srca(s)));
    chk("rnd_alusrcb", k, 32'(sb[k]), 32'(exp_srcb(s)));
    chk("rnd_aluop", k, 32'(aop[k]), (s == 4'd6 || s == 4'd7) ? 2 : (s == 4'd9) ? 1 : 0);
    chk("rnd_immsrc", k, 32'(imm[k]), 32'(exp_imm(op[k])));
    chk("rnd_illegal", k, 32'(ill[k]), 32'(mill[k]));
    chk("rnd_instret", k, iret[k], mret[k] & mask[k]);
  endtask

  task automatic advance(input int unsigned k);
    step_t s;
    if (rst[k]) begin
      n[k] = 0; pos[k] = 0; mret[k] = 0; mill[k] = 1'b0; illc[k] = 0;
      return;
    end
    s = seq[k][pos[k]];
    if (s.st == 4'd15) begin
      illc[k]++;
    end else if (!(s.mem && !rdy[k])) begin
      if (s.last) mret[k]++;
      pos[k]++;
      if (pos[k] < n[k] && seq[k][pos[k]].st == 4'd15) mill[k] = 1'b1;
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; op[k] = OP_I; f3[k] = 3'd0; z[k] = 1'b0; rdy[k] = 1'b0;
    end

    // dut0: lw with two wait cycles in FETCH and MEMREAD
    addv(0,0,OP_LW,2,0,0,  0, 0,0,0,1,0, 0);
    addv(0,0,OP_LW,2,0,0,  0, 0,0,0,1,0, 0);
    addv(0,0,OP_LW,2,0,1,  0, 0,1,0,1,0, 0);
    addv(0,0,OP_LW,2,0,1,  1, 0,0,0,0,0, 0);
    addv(0,0,OP_LW,2,0,1,  2, 0,0,0,0,0, 0);
    addv(0,0,OP_LW,2,0,0,  3, 0,0,0,1,0, 0);
    addv(0,0,OP_LW,2,0,0,  3, 0,0,0,1,0, 0);
    addv(0,0,OP_LW,2,0,1,  3, 0,0,0,1,0, 0);
    addv(0,0,OP_LW,2,0,1,  4, 1,0,0,0,0, 0);
    // beq taken, beq not taken, bne taken
    addv(0,0,OP_BR,0,1,1,  0, 0,1,0,1,0, 1);
    addv(0,0,OP_BR,0,1,1,  1, 0,0,0,0,0, 1);
    addv(0,0,OP_BR,0,1,1,  9, 0,1,0,0,0, 1);
    addv(0,0,OP_BR,0,0,1,  0, 0,1,0,1,0, 2);
    addv(0,0,OP_BR,0,0,1,  1, 0,0,0,0,0, 2);
    addv(0,0,OP_BR,0,0,1,  9, 0,0,0,0,0, 2);
    addv(0,0,OP_BR,1,0,1,  0, 0,1,0,1,0, 3);
    addv(0,0,OP_BR,1,0,1,  1, 0,0,0,0,0, 3);
    addv(0,0,OP_BR,1,0,1,  9, 0,1,0,0,0, 3);
    // jal then jalr
    addv(0,0,OP_JAL,0,0,1, 0, 0,1,0,1,0, 4);
    addv(0,0,OP_JAL,0,0,1, 1, 0,0,0,0,0, 4);
    addv(0,0,OP_JAL,0,0,1, 10,0,1,0,0,0, 4);
    addv(0,0,OP_JAL,0,0,1, 8, 1,0,0,0,0, 4);
    addv(0,0,OP_JALR,0,0,1,0, 0,1,0,1,0, 5);
    addv(0,0,OP_JALR,0,0,1,1, 0,0,0,0,0, 5);
    addv(0,0,OP_JALR,0,0,1,11,0,0,0,0,0, 5);
    addv(0,0,OP_JALR,0,0,1,12,0,1,0,0,0, 5);
    addv(0,0,OP_JALR,0,0,1,8, 1,0,0,0,0, 5);
    // sw with one wait cycle
    addv(0,0,OP_SW,2,0,1,  0, 0,1,0,1,0, 6);
    addv(0,0,OP_SW,2,0,1,  1, 0,0,0,0,0, 6);
    addv(0,0,OP_SW,2,0,1,  2, 0,0,0,0,0, 6);
    addv(0,0,OP_SW,2,0,0,  5, 0,0,1,1,0, 6);
    addv(0,0,OP_SW,2,0,1,  5, 0,0,1,1,0, 6);
    // illegal trap, held ten cycles, then reset
    addv(0,0,OP_BAD,0,1,1, 0, 0,1,0,1,0, 7);
    addv(0,0,OP_BAD,0,1,1, 1, 0,0,0,0,0, 7);
    for (int i = 0; i < 10; i++) addv(0,0,OP_BAD,0,1,1, 15, 0,0,0,0,1, 7);
    addv(0,1,OP_BAD,0,1,1, 15, 0,0,0,0,1, 7);
    addv(0,0,OP_BAD,0,1,0, 0, 0,0,0,1,0, 0);
    // dut1: illegal op and illegal branch funct3 retire as nops
    addv(1,0,OP_BAD,0,0,1, 0, 0,1,0,1,0, 0);
    addv(1,0,OP_BAD,0,0,1, 1, 0,0,0,0,0, 0);
    addv(1,0,OP_BR,2,0,1,  0, 0,1,0,1,0, 1);
    addv(1,0,OP_BR,2,0,1,  1, 0,0,0,0,0, 1);
    // reset asserted mid-store with memory not ready
    addv(1,0,OP_SW,2,0,1,  0, 0,1,0,1,0, 2);
    addv(1,0,OP_SW,2,0,1,  1, 0,0,0,0,0, 2);
    addv(1,0,OP_SW,2,0,1,  2, 0,0,0,0,0, 2);
    addv(1,0,OP_SW,2,0,0,  5, 0,0,1,1,0, 2);
    addv(1,1,OP_SW,2,0,0,  5, 0,0,0,0,0, 2);
    addv(1,0,OP_SW,2,0,0,  0, 0,0,0,1,0, 0);

    reset_dut(0);
    reset_dut(1);

    for (int i = 0; i < tbl.size(); i++) begin
      vec_t v;
      v = tbl[i];
      @(negedge clk);
      rst[v.d] = v.r; op[v.d] = v.o; f3[v.d] = v.f; z[v.d] = v.zz; rdy[v.d] = v.rd;
      #1;
      chk($sformatf("row%0d_state", i),    v.d, 32'(st[v.d]),  32'(v.s));
      chk($sformatf("row%0d_regwrite", i), v.d, 32'(rw[v.d]),  32'(v.w));
      chk($sformatf("row%0d_pcwrite", i),  v.d, 32'(pcw[v.d]), 32'(v.p));
      chk($sformatf("row%0d_memwrite", i), v.d, 32'(mw[v.d]),  32'(v.m));
      chk($sformatf("row%0d_memreq", i),   v.d, 32'(mq[v.d]),  32'(v.q));
      chk($sformatf("row%0d_illegal", i),  v.d, 32'(ill[v.d]), 32'(v.i));
      chk($sformatf("row%0d_instret", i),  v.d, iret[v.d],     v.rt);
    end

    // 4-bit counter wraps after 16 addi instructions
    reset_dut(1);
    for (int k = 0; k < 16; k++) begin
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        op[1] = OP_I; f3[1] = 3'd0; rdy[1] = 1'b1;
        #1;
        if (c == 0) begin
          chk("wrap_state", 1, 32'(st[1]), 0);
          chk("wrap_instret", 1, iret[1], k);
        end
      end
    end
    @(negedge clk);
    rdy[1] = 1'b0;
    #1;
    chk("wrap_state_end", 1, 32'(st[1]), 0);
    chk("wrap_instret_zero", 1, iret[1], 0);

    // randomized instruction stream on both instances
    trap[0] = 1'b1; trap[1] = 1'b0;
    mask[0] = 32'hFFFF_FFFF; mask[1] = 32'h0000_000F;
    reset_dut(0);
    reset_dut(1);
    for (int k = 0; k < 2; k++) begin
      n[k] = 0; pos[k] = 0; mret[k] = 0; mill[k] = 1'b0; illc[k] = 0;
    end
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (pos[k] >= n[k]) new_instr(k);
        rst[k] = (seq[k][pos[k]].st == 4'd15 && illc[k] >= 3);
        z[k]   = 1'($urandom_range(0, 1));
        rdy[k] = ($urandom_range(0, 3) != 0);
      end
      #1;
      for (int k = 0; k < 2; k++) begin
        check_model(k);
        advance(k);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
